// File: rtl/pdp8_pkg.sv
// Shared types for the PDP-8 front end: decoded opcode structs, opcode field
// values, and the fetch/decode FSM state encoding.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    // Bits of the current-page field in an address.
    localparam logic [11:0] PAGE_MASK = 12'o7600;

    typedef struct packed {
        logic and_op;
        logic tad;
        logic isz;
        logic dca;
        logic jms;
        logic jmp;
        logic indirect;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic cla;
        logic cll;
        logic cma;
        logic cml;
        logic rar;
        logic ral;
        logic rtr;
        logic rtl;
        logic iac;
        logic sma;
        logic spa;
        logic sza;
        logic sna;
        logic snl;
        logic szl;
        logic osr;
        logic hlt;
    } pdp_op7_opcode_s;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        ISSUE  = 3'd3,
        BUSY   = 3'd4,
        HALTED = 3'd5
    } dec_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Pure combinational field decode of one PDP-8 instruction word into the
// memory-reference / operate structs and the effective operand address.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

import pdp8_pkg::*;

module instr_field_decode (
    input  logic [11:0]             ir,
    input  logic [`ADDR_WIDTH-1:0]  pc_fetch,
    output logic [`ADDR_WIDTH-1:0]  base_addr,
    output pdp_mem_opcode_s         mem_op,
    output pdp_op7_opcode_s         op7_op
);

    logic [2:0]  opc;
    logic [11:0] page_base;

    assign opc       = ir[11:9];
    assign page_base = ir[7] ? (pc_fetch & PAGE_MASK) : 12'o0000;
    assign base_addr = page_base | {5'b0, ir[6:0]};

    always_comb begin
        mem_op = '0;
        op7_op = '0;
        case (opc)
            OP_AND: mem_op.and_op = 1'b1;
            OP_TAD: mem_op.tad    = 1'b1;
            OP_ISZ: mem_op.isz    = 1'b1;
            OP_DCA: mem_op.dca    = 1'b1;
            OP_JMS: mem_op.jms    = 1'b1;
            OP_JMP: mem_op.jmp    = 1'b1;
            OP_OPR: begin
                if (!ir[8]) begin
                    // Group 1: IR[1] turns a single rotate into a rotate-twice.
                    op7_op.cla = ir[7];
                    op7_op.cll = ir[6];
                    op7_op.cma = ir[5];
                    op7_op.cml = ir[4];
                    op7_op.rar = ir[3] & ~ir[1];
                    op7_op.rtr = ir[3] &  ir[1];
                    op7_op.ral = ir[2] & ~ir[1];
                    op7_op.rtl = ir[2] &  ir[1];
                    op7_op.iac = ir[0];
                end else if (!ir[0]) begin
                    // Group 2: IR[3] flips every skip condition to its inverse.
                    op7_op.cla = ir[7];
                    op7_op.sma = ir[6] & ~ir[3];
                    op7_op.spa = ir[6] &  ir[3];
                    op7_op.sza = ir[5] & ~ir[3];
                    op7_op.sna = ir[5] &  ir[3];
                    op7_op.snl = ir[4] & ~ir[3];
                    op7_op.szl = ir[4] &  ir[3];
                    op7_op.osr = ir[2];
                    op7_op.hlt = ir[1];
                end
            end
            default: ;
        endcase
        if (opc <= OP_JMP)
            mem_op.indirect = ir[8];
    end

endmodule

// File: rtl/instr_decode.sv
// PDP-8 fetch/decode front end: fetches one word per instruction, issues the
// decoded opcode structs for a single cycle, then waits on the execution unit.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

import pdp8_pkg::*;

module instr_decode (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic [`ADDR_WIDTH-1:0]  PC_value,
    output logic                    ifu_rd_req,
    output logic [`ADDR_WIDTH-1:0]  ifu_rd_addr,
    input  logic [`DATA_WIDTH-1:0]  ifu_rd_data,
    output logic [`ADDR_WIDTH-1:0]  base_addr,
    output pdp_mem_opcode_s         pdp_mem_opcode,
    output pdp_op7_opcode_s         pdp_op7_opcode
);

    dec_state_e             state, next_state;
    logic [11:0]            ir;
    logic [`ADDR_WIDTH-1:0] pc_fetch;
    logic [`ADDR_WIDTH-1:0] base_hold;
    logic [`ADDR_WIDTH-1:0] dec_base;
    pdp_mem_opcode_s        dec_mem;
    pdp_op7_opcode_s        dec_op7;

    instr_field_decode u_field_decode (
        .ir        (ir),
        .pc_fetch  (pc_fetch),
        .base_addr (dec_base),
        .mem_op    (dec_mem),
        .op7_op    (dec_op7)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ir        <= '0;
            pc_fetch  <= '0;
            base_hold <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH)
                pc_fetch <= PC_value;
            if (state == LOAD)
                ir <= ifu_rd_data;
            if (state == ISSUE)
                base_hold <= dec_base;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = ISSUE;
            ISSUE:   next_state = dec_op7.hlt ? HALTED : BUSY;
            BUSY:    next_state = stall ? BUSY : FETCH;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // All outputs are functions of registered state, so reset clears them at once.
    always_comb begin
        ifu_rd_req     = 1'b0;
        ifu_rd_addr    = '0;
        base_addr      = base_hold;
        pdp_mem_opcode = '0;
        pdp_op7_opcode = '0;
        if (state == FETCH) begin
            ifu_rd_req  = 1'b1;
            ifu_rd_addr = PC_value;
        end
        if (state == ISSUE) begin
            base_addr      = dec_base;
            pdp_mem_opcode = dec_mem;
            pdp_op7_opcode = dec_op7;
        end
    end

    a_struct_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !((|pdp_mem_opcode) && (|pdp_op7_opcode)));

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: a word-addressed memory model answers the
// fetch port one cycle later; each vector carries hand-computed expectations.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module tb_instr_decode;
    import pdp8_pkg::*;

    logic            clk;
    logic            reset_n;
    logic            stall;
    logic [11:0]     PC_value;
    logic            ifu_rd_req;
    logic [11:0]     ifu_rd_addr;
    logic [11:0]     ifu_rd_data;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s pdp_mem_opcode;
    pdp_op7_opcode_s pdp_op7_opcode;

    logic [11:0]     mem [0:4095];
    int              checks;
    int              failures;

    instr_decode dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .PC_value       (PC_value),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (ifu_rd_req)
            ifu_rd_data <= mem[ifu_rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release stall from BUSY/IDLE, follow one instruction through FETCH,
    // LOAD and ISSUE, and check the cycle after ISSUE is quiet.
    task automatic run_instr(input string tag, input logic [11:0] pc, input logic [11:0] word,
                             input pdp_mem_opcode_s exp_mem, input pdp_op7_opcode_s exp_op7,
                             input logic [11:0] exp_base, input int exp_wait);
        int waited;
        mem[pc]  = word;
        PC_value = pc;
        stall    = 1'b0;
        waited   = 0;
        #1;
        while (!ifu_rd_req && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, "_wait"}, waited, exp_wait);
        chk({tag, "_rd_addr"}, ifu_rd_addr, pc);
        stall = 1'b1;
        step();
        chk({tag, "_req_one"}, ifu_rd_req, 0);
        step();
        chk({tag, "_mem"}, pdp_mem_opcode, exp_mem);
        chk({tag, "_op7"}, pdp_op7_opcode, exp_op7);
        chk({tag, "_base"}, base_addr, exp_base);
        step();
        chk({tag, "_post_zero"}, {pdp_mem_opcode, pdp_op7_opcode}, 0);
        chk({tag, "_base_held"}, base_addr, exp_base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        pdp_mem_opcode_s em;
        pdp_op7_opcode_s eo;
        pdp_op7_opcode_s zo;
        pdp_mem_opcode_s zm;
        int cnt;

        checks   = 0;
        failures = 0;
        zm       = '0;
        zo       = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 12'o0000;
        reset_n  = 1'b1;
        stall    = 1'b1;
        PC_value = 12'o0200;

        #3 reset_n = 1'b0;
        #1;
        chk("rst_req", ifu_rd_req, 0);
        chk("rst_addr", ifu_rd_addr, 0);
        chk("rst_base", base_addr, 0);
        chk("rst_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
        step();
        step();
        reset_n = 1'b1;

        em = '0; em.tad = 1'b1;
        run_instr("tad", 12'o0200, 12'o1377, em, zo, 12'o0377, 1);

        em = '0; em.dca = 1'b1;
        run_instr("dca", 12'o0201, 12'o3010, em, zo, 12'o0010, 1);

        // Five stalled BUSY cycles with a new PC already presented.
        PC_value = 12'o0400;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ifu_rd_req) cnt++;
        end
        chk("stall_no_req", cnt, 0);
        chk("stall_base_held", base_addr, 12'o0010);

        em = '0; em.jmp = 1'b1; em.indirect = 1'b1;
        run_instr("jmp", 12'o0400, 12'o5610, em, zo, 12'o0410, 1);

        run_instr("iot", 12'o0401, 12'o6031, zm, zo, 12'o0031, 1);
        run_instr("grp3", 12'o0402, 12'o7421, zm, zo, 12'o0021, 1);

        eo = '0; eo.cla = 1'b1; eo.iac = 1'b1;
        run_instr("cla_iac", 12'o7777, 12'o7201, zm, eo, 12'o7601, 1);

        // Abort a fetch during LOAD; the TAD word must never issue.
        mem[12'o0300] = 12'o1377;
        PC_value = 12'o0300;
        stall = 1'b0;
        step();
        chk("abort_fetch", ifu_rd_req, 1);
        stall = 1'b1;
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_rst_req", ifu_rd_req, 0);
        chk("abort_rst_base", base_addr, 0);
        chk("abort_rst_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
        step();
        step();
        chk("abort_hold_structs", {pdp_mem_opcode, pdp_op7_opcode}, 0);
        reset_n = 1'b1;

        em = '0; em.dca = 1'b1;
        run_instr("after_abort", 12'o0500, 12'o3010, em, zo, 12'o0010, 1);

        eo = '0; eo.hlt = 1'b1;
        run_instr("hlt", 12'o0501, 12'o7402, zm, eo, 12'o0002, 1);

        stall = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifu_rd_req || (|pdp_mem_opcode) || (|pdp_op7_opcode)) cnt++;
        end
        chk("halted_quiet", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have ports clk input 1 (single clock) and reset_n input 1; reset is asynchronous and active-low.
REQ-002 SHALL have ports stall input 1 (execution unit busy) and PC_value input `ADDR_WIDTH (address of next instruction, from the execution unit).
REQ-003 SHALL have ports ifu_rd_req output 1, ifu_rd_addr output `ADDR_WIDTH and ifu_rd_data input `DATA_WIDTH (instruction memory read port; data is valid the cycle after the request).
REQ-004 SHALL have ports base_addr output `ADDR_WIDTH (effective operand address), pdp_mem_opcode output pdp8_pkg::pdp_mem_opcode_s and pdp_op7_opcode output pdp8_pkg::pdp_op7_opcode_s.

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, LOAD, ISSUE, BUSY, HALTED.
REQ-006 IDLE SHALL last one cycle after reset release, then go to FETCH.
REQ-007 FETCH SHALL assert ifu_rd_req for exactly one cycle with ifu_rd_addr=PC_value, then go to LOAD.
REQ-008 LOAD SHALL capture ifu_rd_data into a 12-bit instruction register IR, then go to ISSUE.
REQ-009 ISSUE SHALL drive decoded opcode structs for exactly one cycle, then go to BUSY, or to HALTED if the instruction is HLT.
REQ-010 BUSY SHALL stay while stall=1 and go to FETCH in the first cycle with stall=0. The execution unit contract is that stall=1 in the first BUSY cycle and stays 1 until PC_value is valid.
REQ-011 HALTED SHALL be absorbing until reset; ifu_rd_req stays 0.
REQ-012 Decode SHALL use IR[11:9] as opcode: 0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP, 6 IOT, 7 OPR.
REQ-013 For opcodes 0-5, exactly one matching pdp_mem_opcode flag SHALL be 1, and pdp_mem_opcode.indirect SHALL equal IR[8].
REQ-014 base_addr SHALL be {PC_fetch[11:7], IR[6:0]} when IR[7]=1 (current page), else {5'b0, IR[6:0]}. PC_fetch is the PC_value registered at FETCH.
REQ-015 base_addr SHALL be held from ISSUE until the next ISSUE.
REQ-016 For OPR with IR[8]=0 (group 1), the decoder SHALL set the cla, cll, cma, cml, rar, ral, rtr, rtl, iac flags from IR[7:0]. Rotate pairs use IR[3:1]; IR[1] with IR[3] or IR[2] SHALL set rtr or rtl.
REQ-017 For OPR with IR[8]=1 and IR[0]=0 (group 2), the decoder SHALL set cla, sma/spa, sza/sna, snl/szl, osr and hlt from IR[7:1]. IR[3] selects the inverted sense.
REQ-018 Outside ISSUE, both opcode structs SHALL be all-zero. IOT and group-3 OPR (IR[8]=1, IR[0]=1) SHALL also issue all-zero structs and proceed to BUSY.
REQ-019 The mem and op7 structs SHALL never be nonzero simultaneously.
REQ-020 PC wrap SHALL be the execution unit's concern; the decoder fetches any PC_value including 12'o7777 unchanged.

Reset
REQ-021 Asserting reset_n=0 SHALL immediately force: state IDLE, IR=0, PC_fetch=0, base_addr=0, ifu_rd_req=0, ifu_rd_addr=0, both structs all-zero.
REQ-022 Reset asserted mid-FETCH, mid-LOAD or mid-BUSY SHALL discard the in-flight instruction; no ISSUE follows until a fresh FETCH.

Structure
REQ-023 pdp8_pkg SHALL hold: pdp_mem_opcode_s, pdp_op7_opcode_s, opcode field constants (OP_AND..OP_OPR), `ADDR_WIDTH/`DATA_WIDTH (12), and the FSM state enum.
REQ-024 Decode SHALL be a combinational sub-module, instr_field_decode (IR, PC_fetch -> base_addr, structs), registered by instr_decode in ISSUE.

Verification
REQ-025 PC_value=12'o0200, mem[0o200]=12'o1377 -> ifu_rd_addr=12'o0200, ISSUE with tad=1, indirect=0, base_addr=12'o0377.
REQ-026 mem=12'o3010 -> dca=1, base_addr=12'o0010; mem=12'o5610 at PC 12'o0400 -> jmp=1, indirect=1, base_addr=12'o0410.
REQ-027 mem=12'o7201 -> op7 cla=1, iac=1, mem struct zero; mem=12'o7402 -> hlt=1, then HALTED with no ifu_rd_req for 20 cycles.
REQ-028 stall held 1 for 5 BUSY cycles -> no ifu_rd_req during them; FETCH occurs exactly 1 cycle after stall falls, using the new PC_value.
REQ-029 reset_n pulsed low during LOAD -> all outputs zero asynchronously; no ISSUE for the aborted word; the next fetch follows IDLE.
REQ-030 mem=12'o6031 (IOT) and 12'o7421 (group 3) -> ISSUE with all-zero structs, FSM continues to BUSY.
